// File: rtl/w0rm_core_data_ram.sv
// w0rm_core_data_ram
//   Word-addressed on-chip data RAM that sits behind the core memory stage.
//   A single-cycle request pulse is latched, held for WAIT_STATES extra
//   cycles, then completed with a one-cycle bus_valid_o pulse. Misaligned
//   and out-of-window accesses complete with bus_error_o so the memory stage
//   never stalls forever.
//
// Ports
//   clk, reset_n            clock / asynchronous active-low reset
//   bus_valid_i             request strobe (1-cycle pulse)
//   bus_write_i/bus_read_i  request kind, qualified by bus_valid_i
//   bus_addr_i              byte address
//   bus_data_i              write data
//   bus_valid_o             completion pulse
//   bus_data_o              read data (held between completions)
//   bus_error_o             completion was an error (valid with bus_valid_o)
//   busy_o                  request in flight; new requests are ignored
module w0rm_core_data_ram #(
  parameter int              ADDR_WIDTH  = 32,
  parameter int              DATA_WIDTH  = 32,
  parameter int              DEPTH_LOG2  = 10,
  parameter longint unsigned BASE_ADDR   = 0,
  parameter int              WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bus_valid_i,
  input  logic                  bus_write_i,
  input  logic                  bus_read_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  bus_valid_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_error_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Window size in bytes, one bit wider than the address so it cannot wrap.
  localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH+1)'(DEPTH) << 2;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic                  r_wr;
  logic                  r_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;
  logic                  w_accept;
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Subtraction wraps, so addresses below the base land far out of window.
  assign w_off    = r_addr - ADDR_WIDTH'(BASE_ADDR);
  assign w_idx    = w_off[DEPTH_LOG2+1:2];
  assign w_err    = (r_addr[1:0] != 2'b00) || ({1'b0, w_off} >= WIN_BYTES);
  assign w_accept = bus_valid_i && (bus_write_i || bus_read_i) &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_fire   = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_rdata  = r_mem[w_idx];

  // DONE counts as busy only when it is taking the next request this cycle.
  assign busy_o   = (r_state == S_WAIT) || ((r_state == S_DONE) && w_accept);

  // RAM is never reset; contents survive reset_n. The write happens on the
  // completion edge, so a reset during WAIT discards it.
  always_ff @(posedge clk) begin
    if (w_fire && r_wr && !w_err) r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      bus_valid_o <= 1'b0;
      bus_data_o  <= '0;
      bus_error_o <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            bus_valid_o <= 1'b1;
            bus_error_o <= w_err;
            // Read-before-write when both are set: old word is returned.
            bus_data_o  <= (w_err || !r_rd) ? '0 : w_rdata;
            r_state     <= S_DONE;
          end
        end
        default: begin
          bus_valid_o <= 1'b0;
          bus_error_o <= 1'b0;
          if (w_accept) begin
            r_wr    <= bus_write_i;
            r_rd    <= bus_read_i;
            r_addr  <= bus_addr_i;
            r_wdata <= bus_data_i;
            r_cnt   <= 8'(WAIT_STATES);
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w0rm_core_data_ram.sv
// Bench for w0rm_core_data_ram. Three instances with different wait states /
// base addresses are driven independently; a word-level model (associative
// array keyed by instance and word) predicts data and error completions.
module tb_w0rm_core_data_ram;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        bv [3];
  logic        bw [3];
  logic        br [3];
  logic [31:0] ba [3];
  logic [31:0] bd [3];
  logic        vo [3];
  logic        eo [3];
  logic        bsy[3];
  logic [31:0] dout[3];

  int unsigned ws_of  [3] = '{1, 0, 3};
  logic [31:0] base_of[3] = '{32'h0, 32'h0, 32'h8000};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    w0rm_core_data_ram #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_LOG2 (10),
      .BASE_ADDR  ((g == 2) ? 64'h8000 : 64'h0),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus_valid_i(bv[g]),
      .bus_write_i(bw[g]),
      .bus_read_i (br[g]),
      .bus_addr_i (ba[g]),
      .bus_data_i (bd[g]),
      .bus_valid_o(vo[g]),
      .bus_data_o (dout[g]),
      .bus_error_o(eo[g]),
      .busy_o     (bsy[g])
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl [longint];

  function automatic void model(input int k, input bit w, input bit r,
                                input logic [31:0] a, input logic [31:0] d,
                                output bit e, output logic [31:0] q,
                                output bit known);
    logic [31:0] off;
    longint key;
    off   = a - base_of[k];
    e     = (a % 4 != 0) || (off >= 32'd4096);
    q     = 32'h0;
    known = 1'b1;
    if (!e) begin
      key = longint'(k) * 4096 + longint'(off / 4);
      if (r) begin
        if (mdl.exists(key)) q = mdl[key];
        else known = 1'b0;
      end
      if (w) mdl[key] = d;
    end
  endfunction

  typedef struct {
    bit          got;
    int          lat;
    logic [31:0] q;
    bit          e;
    bit          busy_wait;
    bit          busy_done;
    bit          pulse1;
    bit          hold;
  } res_t;

  // Drives one request on instance k and observes its completion.
  task automatic req(input int k, input bit w, input bit r,
                     input logic [31:0] a, input logic [31:0] d,
                     output res_t res);
    res = '{default: 0};
    @(posedge clk); #1;
    bv[k] = 1'b1; bw[k] = w; br[k] = r; ba[k] = a; bd[k] = d;
    @(posedge clk); #1;                 // edge N has sampled the request
    bv[k] = 1'b0; bw[k] = 1'b0; br[k] = 1'b0;
    res.busy_wait = bsy[k];
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (vo[k]) begin
        res.got = 1'b1; res.lat = i; res.q = dout[k]; res.e = eo[k];
        res.busy_done = bsy[k];
        break;
      end
      res.busy_wait &= bsy[k];
    end
    if (res.got) begin
      @(posedge clk); #1;
      res.pulse1 = !vo[k];
      res.hold   = (dout[k] === res.q);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bv[k] = 0; bw[k] = 0; br[k] = 0; ba[k] = 0; bd[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({vo[k], eo[k], bsy[k], dout[k]} !== 35'h0) begin
        errors++;
        $display("FAIL reset_state[%0d] got v=%b e=%b busy=%b d=%h want all 0",
                 k, vo[k], eo[k], bsy[k], dout[k]);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    res_t res;
    bit e, kn; logic [31:0] q;
    model(0, 1, 0, 32'h10, 32'hDEADBEEF, e, q, kn);
    req(0, 1, 0, 32'h10, 32'hDEADBEEF, res);
    checks++;
    if (!res.got || res.lat != 2 || res.e !== 1'b0 || res.q !== 32'h0 || !res.pulse1) begin
      errors++;
      $display("FAIL wr_0x10 got=%b lat=%0d e=%b d=%h pulse1=%b want 1/2/0/0/1",
               res.got, res.lat, res.e, res.q, res.pulse1);
    end
    model(0, 0, 1, 32'h10, 32'h0, e, q, kn);
    req(0, 0, 1, 32'h10, 32'h0, res);
    checks++;
    if (!res.got || res.lat != 2 || res.e !== 1'b0 || res.q !== q || !res.pulse1 || !res.hold) begin
      errors++;
      $display("FAIL rd_0x10 got=%b lat=%0d e=%b d=%h pulse1=%b hold=%b want d=%h",
               res.got, res.lat, res.e, res.q, res.pulse1, res.hold, q);
    end
  endtask

  task automatic test_latency();
    res_t res;
    bit e, kn; logic [31:0] q;
    model(1, 1, 0, 32'h0, 32'h0BAD_F00D, e, q, kn);
    req(1, 1, 0, 32'h0, 32'h0BAD_F00D, res);
    model(1, 0, 1, 32'h0, 32'h0, e, q, kn);
    req(1, 0, 1, 32'h0, 32'h0, res);
    checks++;
    if (!res.got || res.lat != 1 || res.q !== q || !res.pulse1) begin
      errors++;
      $display("FAIL ws0_latency got=%b lat=%0d d=%h pulse1=%b want lat 1 d=%h",
               res.got, res.lat, res.q, res.pulse1, q);
    end
    model(2, 1, 0, 32'h8000, 32'h5A5A_0001, e, q, kn);
    req(2, 1, 0, 32'h8000, 32'h5A5A_0001, res);
    model(2, 0, 1, 32'h8000, 32'h0, e, q, kn);
    req(2, 0, 1, 32'h8000, 32'h0, res);
    checks++;
    if (!res.got || res.lat != 4 || res.q !== q || !res.pulse1) begin
      errors++;
      $display("FAIL ws3_latency got=%b lat=%0d d=%h pulse1=%b want lat 4 d=%h",
               res.got, res.lat, res.q, res.pulse1, q);
    end
    checks++;
    if (res.busy_wait !== 1'b1 || res.busy_done !== 1'b0) begin
      errors++;
      $display("FAIL ws3_busy wait=%b done=%b want 1/0", res.busy_wait, res.busy_done);
    end
  endtask

  task automatic test_errors();
    res_t res;
    bit e, kn; logic [31:0] q;
    req(0, 0, 1, 32'h12, 32'h0, res);
    checks++;
    if (!res.got || res.e !== 1'b1 || res.q !== 32'h0 || res.lat != 2) begin
      errors++;
      $display("FAIL misaligned got=%b e=%b d=%h lat=%0d want e=1 d=0", res.got, res.e, res.q, res.lat);
    end
    req(0, 0, 1, 32'h1000, 32'h0, res);
    checks++;
    if (!res.got || res.e !== 1'b1 || res.q !== 32'h0) begin
      errors++;
      $display("FAIL out_of_window got=%b e=%b d=%h want e=1 d=0", res.got, res.e, res.q);
    end
    model(0, 1, 0, 32'h0, 32'h1111_2222, e, q, kn);
    req(0, 1, 0, 32'h0, 32'h1111_2222, res);
    req(0, 1, 0, 32'h1000, 32'h9999_9999, res);
    checks++;
    if (!res.got || res.e !== 1'b1) begin
      errors++;
      $display("FAIL oow_write_err got=%b e=%b want e=1", res.got, res.e);
    end
    model(0, 0, 1, 32'h0, 32'h0, e, q, kn);
    req(0, 0, 1, 32'h0, 32'h0, res);
    checks++;
    if (res.q !== q || res.e !== 1'b0) begin
      errors++;
      $display("FAIL oow_write_no_alias d=%h e=%b want d=%h", res.q, res.e, q);
    end
    model(0, 1, 0, 32'hFFC, 32'hCAFE_0FFC, e, q, kn);
    req(0, 1, 0, 32'hFFC, 32'hCAFE_0FFC, res);
    model(0, 0, 1, 32'hFFC, 32'h0, e, q, kn);
    req(0, 0, 1, 32'hFFC, 32'h0, res);
    checks++;
    if (!res.got || res.e !== 1'b0 || res.q !== q) begin
      errors++;
      $display("FAIL last_word got=%b e=%b d=%h want e=0 d=%h", res.got, res.e, res.q, q);
    end
  endtask

  task automatic test_base();
    res_t res;
    bit e, kn; logic [31:0] q;
    req(2, 0, 1, 32'h7FFC, 32'h0, res);
    checks++;
    if (!res.got || res.e !== 1'b1 || res.q !== 32'h0) begin
      errors++;
      $display("FAIL below_base got=%b e=%b d=%h want e=1 d=0", res.got, res.e, res.q);
    end
    model(2, 0, 1, 32'h8000, 32'h0, e, q, kn);
    req(2, 0, 1, 32'h8000, 32'h0, res);
    checks++;
    if (!res.got || res.e !== 1'b0 || res.q !== q) begin
      errors++;
      $display("FAIL at_base got=%b e=%b d=%h want e=0 d=%h", res.got, res.e, res.q, q);
    end
  endtask

  task automatic test_ignored();
    int seen = 0;
    @(posedge clk); #1;
    bv[0] = 1'b1; bw[0] = 1'b0; br[0] = 1'b0; ba[0] = 32'h10;
    @(posedge clk); #1;
    bv[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vo[0] || bsy[0]) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_rw_ignored active_cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit e, kn; logic [31:0] q;
    bit got;
    int lat, cnt;
    bit busy_accept;
    logic [31:0] val;
    val = $urandom;
    model(0, 1, 0, 32'h40, val, e, q, kn);
    model(0, 0, 1, 32'h40, 32'h0, e, q, kn);
    @(posedge clk); #1;
    bv[0] = 1'b1; bw[0] = 1'b1; br[0] = 1'b0; ba[0] = 32'h40; bd[0] = val;
    @(posedge clk); #1;
    bv[0] = 1'b0; bw[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      got = vo[0];
    end
    // In the DONE cycle, present the next request.
    bv[0] = 1'b1; br[0] = 1'b1; ba[0] = 32'h40;
    #1 busy_accept = bsy[0];
    @(posedge clk); #1;
    bv[0] = 1'b0; br[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (vo[0]) begin lat = i; break; end
    end
    checks++;
    if (!got || lat != 2 || dout[0] !== q || eo[0] !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back first=%b lat=%0d d=%h want lat 2 d=%h", got, lat, dout[0], q);
    end
    checks++;
    if (busy_accept !== 1'b1) begin
      errors++;
      $display("FAIL busy_done_accept got %b want 1", busy_accept);
    end

    // Pulse injected during WAIT on the 3-wait-state instance is dropped.
    model(2, 1, 0, 32'h8004, 32'h7777_0004, e, q, kn);
    begin
      res_t res;
      req(2, 1, 0, 32'h8004, 32'h7777_0004, res);
    end
    @(posedge clk); #1;
    bv[2] = 1'b1; br[2] = 1'b1; ba[2] = 32'h8000;
    @(posedge clk); #1;
    bv[2] = 1'b0; br[2] = 1'b0;
    @(posedge clk); #1;
    bv[2] = 1'b1; bw[2] = 1'b1; ba[2] = 32'h8004; bd[2] = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bv[2] = 1'b0; bw[2] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (vo[2]) cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL wait_inject completions=%0d want 1", cnt);
    end
    model(2, 0, 1, 32'h8004, 32'h0, e, q, kn);
    begin
      res_t res;
      req(2, 0, 1, 32'h8004, 32'h0, res);
      checks++;
      if (res.q !== q) begin
        errors++;
        $display("FAIL wait_inject_no_write d=%h want %h", res.q, q);
      end
    end
  endtask

  task automatic test_random();
    res_t res;
    bit e, kn, w, r;
    logic [31:0] q, a, d;
    int sel;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 30; n++) begin
        sel = $urandom_range(0, 2);
        w = (sel != 1); r = (sel != 0);
        d = $urandom;
        case ($urandom_range(0, 6))
          0: a = base_of[k] + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
          1: a = base_of[k] + 32'd4096 + 4 * $urandom_range(0, 15);
          2: a = base_of[k] - 32'd4;
          3: a = base_of[k] + 32'hFFC;
          default: a = base_of[k] + 32'h100 + 4 * $urandom_range(0, 7);
        endcase
        model(k, w, r, a, d, e, q, kn);
        req(k, w, r, a, d, res);
        checks++;
        if (!res.got || res.lat != int'(1 + ws_of[k]) || res.e !== e ||
            (kn && res.q !== q) || !res.pulse1 || !res.hold) begin
          errors++;
          $display("FAIL random[%0d.%0d] a=%h w=%b r=%b got=%b lat=%0d e=%b d=%h want lat=%0d e=%b d=%h",
                   k, n, a, w, r, res.got, res.lat, res.e, res.q, 1 + ws_of[k], e, q);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    res_t res;
    bit e, kn; logic [31:0] q;
    int seen;
    model(0, 1, 0, 32'h20, 32'h0000_5555, e, q, kn);
    req(0, 1, 0, 32'h20, 32'h0000_5555, res);
    req(0, 0, 1, 32'h20, 32'h0, res);       // leaves nonzero data on the bus
    @(posedge clk); #1;
    bv[0] = 1'b1; bw[0] = 1'b1; ba[0] = 32'h20; bd[0] = 32'h1234;
    @(posedge clk); #1;
    bv[0] = 1'b0; bw[0] = 1'b0;
    reset_n = 1'b0;                          // during WAIT
    #1;
    checks++;
    if ({vo[0], eo[0], bsy[0], dout[0]} !== 35'h0) begin
      errors++;
      $display("FAIL reset_midop_outputs v=%b e=%b busy=%b d=%h want all 0",
               vo[0], eo[0], bsy[0], dout[0]);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (vo[0]) seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (vo[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_midop_no_pulse pulses=%0d want 0", seen);
    end
    model(0, 0, 1, 32'h20, 32'h0, e, q, kn);
    req(0, 0, 1, 32'h20, 32'h0, res);
    checks++;
    if (!res.got || res.q !== q || res.e !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_ram got=%b d=%h want %h", res.got, res.q, q);
    end
    model(0, 1, 1, 32'h20, 32'hABCD_0020, e, q, kn);
    req(0, 1, 1, 32'h20, 32'hABCD_0020, res);
    checks++;
    if (!res.got || res.q !== q || res.e !== 1'b0) begin
      errors++;
      $display("FAIL rmw_old_data got=%b d=%h want %h", res.got, res.q, q);
    end
    model(0, 0, 1, 32'h20, 32'h0, e, q, kn);
    req(0, 0, 1, 32'h20, 32'h0, res);
    checks++;
    if (res.q !== q) begin
      errors++;
      $display("FAIL rmw_new_data d=%h want %h", res.q, q);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_errors();
    test_base();
    test_ignored();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
